// File: rtl/pixel_unshuffle_stream.sv
// Streaming 2x2 space-to-depth: raster pixels in, one unshuffled pixel (4*CHANNELS elements) out
// per 2x2 block, using a single-row line buffer plus a side register for the odd-row even-column pixel.
module pixel_unshuffle_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 4,
  parameter int HEIGHT     = 4,
  parameter int WIDTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [4*CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           busy,
  output logic                           done
);
  localparam int PW = CHANNELS*DATA_WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT-1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t        state;
  logic [CW-1:0] col, col_prev;
  logic [RW-1:0] row;
  logic [PW-1:0] lbuf [WIDTH];
  logic [PW-1:0] side;
  logic [4*PW-1:0] nxt;
  logic          accept, form, last;

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign form     = accept && row[0] && col[0];
  assign last     = accept && (row == ROW_LAST) && (col == COL_LAST);
  assign col_prev = col - CW'(1);

  // Output element k = c*4 + dy*2 + dx
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign nxt[(4*c+0)*DATA_WIDTH +: DATA_WIDTH] = lbuf[col_prev][c*DATA_WIDTH +: DATA_WIDTH];
    assign nxt[(4*c+1)*DATA_WIDTH +: DATA_WIDTH] = lbuf[col][c*DATA_WIDTH +: DATA_WIDTH];
    assign nxt[(4*c+2)*DATA_WIDTH +: DATA_WIDTH] = side[c*DATA_WIDTH +: DATA_WIDTH];
    assign nxt[(4*c+3)*DATA_WIDTH +: DATA_WIDTH] = in_data[c*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (!row[0])      lbuf[col] <= in_data;
      else if (!col[0]) side      <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy  <= 1'b1;
          row   <= '0;
          col   <= '0;
        end
        RUN: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row != ROW_LAST) row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
          if (last) state <= FLUSH;
        end
        FLUSH: if (out_valid && out_ready) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // A new pixel is only formed when the register is free or draining this cycle
      if (form) begin
        out_data  <= nxt;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pixel_unshuffle_stream.sv
// Directed bench for pixel_unshuffle_stream with CHANNELS=2 on a 4x4 frame; ch0 = 4*row+col,
// ch1 = 0xFF00 - ch0, so every output is checked against a hand-written 2x2 block table.
module tb_pixel_unshuffle_stream;
  logic         clk = 1'b0;
  logic         rst, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [31:0]  in_data;
  logic [127:0] out_data;
  int nvec = 0;
  int nbad = 0;

  pixel_unshuffle_stream #(.DATA_WIDTH(16), .CHANNELS(2), .HEIGHT(4), .WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    nvec++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  // ch0 k0..k3 per output block; ch1 elements are 0xFF00 minus the same values
  function automatic logic [127:0] exp_out(input int i);
    int b [4][4] = '{'{0, 1, 4, 5}, '{2, 3, 6, 7}, '{8, 9, 12, 13}, '{10, 11, 14, 15}};
    logic [127:0] r;
    logic [15:0]  e;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      e = 16'(b[i][j]);
      r[j*16 +: 16]     = e;
      r[(4+j)*16 +: 16] = 16'hFF00 - e;
    end
    return r;
  endfunction

  // mode 0 plain, 1 output stall, 2 random handshakes, 3 reset after 6 beats, 4 start while busy
  task automatic run_frame(input int mode);
    int pi = 0, oi = 0, stall = 0, ndone = 0, last_hs = -1, done_cyc = -1;
    logic hin, hout;
    logic [15:0] v;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_on_start", 128'(busy), 128'(1));
    for (int cyc = 0; cyc < 400 && ndone == 0; cyc++) begin
      if (mode == 3 && pi == 6) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_out_data", out_data, 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_done", 128'(done), 128'(0));
        chk("abort_in_ready", 128'(in_ready), 128'(0));
        chk("abort_no_done", 128'(ndone), 128'(0));
        return;
      end
      v = 16'(pi);
      in_valid  = (mode == 2) ? 1'($urandom_range(0, 1)) : (pi < 16);
      in_data   = (in_valid && pi < 16) ? {16'hFF00 - v, v} : $urandom;
      out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 1 && out_valid && oi == 0 && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end
      start = (mode == 4 && pi == 3);
      #1;
      if (mode == 1 && !out_ready) begin
        chk("stall_hold", out_data, exp_out(0));
        chk("stall_in_ready", 128'(in_ready), 128'(0));
      end
      hin  = in_valid && in_ready;
      hout = out_valid && out_ready;
      if (done) begin ndone++; done_cyc = cyc; end
      if (hout) begin
        if (oi < 4) begin
          chk($sformatf("out%0d_m%0d", oi, mode), out_data, exp_out(oi));
          if (oi == 0) chk("sign_k4", 128'($signed(out_data[79:64])), 128'(-256));
        end else begin
          chk("extra_output", 128'(oi), 128'(3));
        end
        oi++;
        last_hs = cyc;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (hin) pi++;
    end
    in_valid = 1'b0;
    chk("one_done", 128'(ndone), 128'(1));
    chk("out_count", 128'(oi), 128'(4));
    chk("in_count", 128'(pi), 128'(16));
    chk("done_latency", 128'(done_cyc - last_hs), 128'(1));
    chk("busy_after", 128'(busy), 128'(0));
    chk("done_pulse_len", 128'(done), 128'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    rst = 1'b0;

    run_frame(0);
    run_frame(1);

    // Idle: in_valid must be ignored
    in_valid = 1'b1; in_data = 32'h1234_5678; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("idle_in_ready", 128'(in_ready), 128'(0));
      chk("idle_out_valid", 128'(out_valid), 128'(0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    run_frame(4);
    for (int f = 0; f < 10; f++) run_frame(2);
    run_frame(3);
    run_frame(0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
